// File: rtl/mopshub_bus_pkg.sv
// Shared constants and grant FSM encoding for the bus-select tracker family.
package mopshub_bus_pkg;

   localparam int unsigned NChDefault  = 32;
   localparam int unsigned SelWDefault = $clog2(NChDefault);
   localparam int unsigned CntWDefault = $clog2(NChDefault + 1);

   typedef enum logic [1:0] {
      StIdle,
      StOffer,
      StGap
   } grant_state_e;

endpackage

// File: rtl/rr_first_set.sv
// Circular priority finder: first set bit of mask searching ptr, ptr+1, ..., wrapping at N_CH.
module rr_first_set #(
   parameter int unsigned N_CH  = 32,
   parameter int unsigned SEL_W = 5
) (
   input  logic [N_CH-1:0]  mask,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   int unsigned cand;

   // ptr is always < N_CH, so one subtraction is enough to wrap
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= N_CH) cand = cand - N_CH;
         if (!found && mask[cand]) begin
            found = 1'b1;
            idx   = SEL_W'(cand);
         end
      end
   end

endmodule

// File: rtl/bus_sel_tracker_nbit.sv
// N_CH-bit bus-active mask with load/set/clear and a round-robin valid/ready grant engine.
module bus_sel_tracker_nbit
   import mopshub_bus_pkg::*;
#(
   parameter int unsigned N_CH     = NChDefault,
   parameter int unsigned SEL_W    = SelWDefault,
   parameter int unsigned CNT_W    = CntWDefault,
   parameter bit          AUTO_CLR = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [N_CH-1:0]  load_mask,
   input  logic             set_en,
   input  logic [SEL_W-1:0] set_sel,
   input  logic             clr_en,
   input  logic [SEL_W-1:0] clr_sel,
   output logic [N_CH-1:0]  mask_out,
   output logic [CNT_W-1:0] active_cnt,
   output logic             mask_empty,
   output logic             grant_valid,
   output logic [SEL_W-1:0] grant_sel,
   input  logic             grant_ready,
   output logic             sel_err
);

   logic [N_CH-1:0]  mask_q, mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             empty_q;
   logic             sel_err_q, sel_err_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   grant_state_e     state_q, state_d;

   logic             set_in_range, clr_in_range;
   logic             set_ok, clr_ok;
   logic             accept, auto_clr;
   logic             found;
   logic [SEL_W-1:0] found_idx;

   assign set_in_range = 32'(set_sel) < N_CH;
   assign clr_in_range = 32'(clr_sel) < N_CH;
   assign set_ok       = set_en && set_in_range;
   assign clr_ok       = clr_en && clr_in_range;
   assign sel_err_d    = (set_en && !set_in_range) || (clr_en && !clr_in_range);
   assign accept       = valid_q && grant_ready;
   assign auto_clr     = AUTO_CLR && accept;

   rr_first_set #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_rr_first_set (
      .mask  (mask_q),
      .ptr   (ptr_q),
      .found (found),
      .idx   (found_idx)
   );

   // Later assignments win: set beats auto-clear, clear beats set.
   always_comb begin
      mask_d = mask_q;
      if (load_en) begin
         mask_d = load_mask;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (auto_clr && 32'(sel_q) == i) mask_d[i] = 1'b0;
            if (set_ok && 32'(set_sel) == i) mask_d[i] = 1'b1;
            if (clr_ok && 32'(clr_sel) == i) mask_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_d = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         cnt_d = cnt_d + CNT_W'(mask_d[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            // Never offer a bit that is being cleared on this very edge
            if (found && mask_d[found_idx]) begin
               sel_d   = found_idx;
               valid_d = 1'b1;
               state_d = StOffer;
            end
         end
         StOffer: begin
            if (accept) begin
               valid_d = 1'b0;
               ptr_d   = (32'(sel_q) == N_CH - 1) ? '0 : sel_q + 1'b1;
               state_d = StGap;
            end else if (!mask_d[sel_q]) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
         StGap: begin
            state_d = StIdle;
         end
         default: begin
            valid_d = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q    <= '0;
         cnt_q     <= '0;
         empty_q   <= 1'b1;
         sel_err_q <= 1'b0;
         valid_q   <= 1'b0;
         sel_q     <= '0;
         ptr_q     <= '0;
         state_q   <= StIdle;
      end else begin
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         empty_q   <= (mask_d == '0);
         sel_err_q <= sel_err_d;
         valid_q   <= valid_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         state_q   <= state_d;
      end
   end

   assign mask_out    = mask_q;
   assign active_cnt  = cnt_q;
   assign mask_empty  = empty_q;
   assign sel_err     = sel_err_q;
   assign grant_valid = valid_q;
   assign grant_sel   = sel_q;

endmodule
